// File: rtl/reg_init_sequencer.sv
// Sensor register-init engine: walks a {reg, value} table and issues one bus write per entry,
// honouring delay/end markers, with optional read-back verification and per-entry retries.
module reg_init_sequencer #(
    parameter int         ROM_AW         = 8,
    parameter int         REG_AW         = 8,
    parameter int         DW             = 8,
    parameter logic [6:0] DEV_ADDR       = 7'h21,
    parameter int         STARTUP_CYCLES = 1000,
    parameter int         DELAY_UNIT     = 1000,
    parameter int         VERIFY         = 0,
    parameter int         RETRIES        = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 start_i,
    output logic [ROM_AW-1:0]    rom_addr_o,
    input  logic [REG_AW+DW-1:0] rom_data_i,
    output logic                 xfer_req_o,
    output logic                 xfer_we_o,
    output logic [6:0]           xfer_dev_o,
    output logic [REG_AW-1:0]    xfer_reg_o,
    output logic [DW-1:0]        xfer_wdata_o,
    input  logic [DW-1:0]        xfer_rdata_i,
    input  logic                 xfer_done_i,
    input  logic                 xfer_err_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [1:0]           fail_code_o,
    output logic [ROM_AW-1:0]    fail_index_o,
    output logic [ROM_AW:0]      write_count_o
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_STARTUP = 4'd1;
    localparam logic [3:0] S_FETCH   = 4'd2;
    localparam logic [3:0] S_DECODE  = 4'd3;
    localparam logic [3:0] S_WR      = 4'd4;
    localparam logic [3:0] S_WR_WAIT = 4'd5;
    localparam logic [3:0] S_RD      = 4'd6;
    localparam logic [3:0] S_RD_WAIT = 4'd7;
    localparam logic [3:0] S_CMP     = 4'd8;
    localparam logic [3:0] S_DELAY   = 4'd9;
    localparam logic [3:0] S_NEXT    = 4'd10;
    localparam logic [3:0] S_DONE    = 4'd11;
    localparam logic [3:0] S_FAIL    = 4'd12;

    logic [3:0]        state_reg;
    logic [ROM_AW-1:0] rom_addr_reg;
    logic [31:0]       cnt_reg;
    logic [DW-1:0]     tick_reg;
    logic [3:0]        retry_reg;
    logic              is_write_reg;
    logic              req_reg;
    logic              we_reg;
    logic [REG_AW-1:0] reg_addr_reg;
    logic [DW-1:0]     wdata_reg;
    logic [DW-1:0]     rdata_reg;
    logic              done_reg;
    logic              error_reg;
    logic [1:0]        fail_code_reg;
    logic [ROM_AW-1:0] fail_index_reg;
    logic [ROM_AW:0]   write_count_reg;

    logic [REG_AW-1:0] rom_ra;
    logic [DW-1:0]     rom_v;
    logic              fail_now;
    logic [1:0]        fail_kind;

    assign rom_ra = rom_data_i[REG_AW+DW-1:DW];
    assign rom_v  = rom_data_i[DW-1:0];

    // Bus errors and verify mismatches share one retry/abort path; error beats a same-cycle done.
    always_comb begin
        fail_now  = 1'b0;
        fail_kind = 2'd0;
        case (state_reg)
            S_WR_WAIT, S_RD_WAIT: begin
                if (xfer_err_i) begin
                    fail_now  = 1'b1;
                    fail_kind = 2'd1;
                end
            end
            S_CMP: begin
                if (rdata_reg != wdata_reg) begin
                    fail_now  = 1'b1;
                    fail_kind = 2'd2;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg       <= S_IDLE;
            rom_addr_reg    <= '0;
            cnt_reg         <= '0;
            tick_reg        <= '0;
            retry_reg       <= '0;
            is_write_reg    <= 1'b0;
            req_reg         <= 1'b0;
            we_reg          <= 1'b0;
            reg_addr_reg    <= '0;
            wdata_reg       <= '0;
            rdata_reg       <= '0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            fail_code_reg   <= 2'd0;
            fail_index_reg  <= '0;
            write_count_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start_i) begin
                        done_reg        <= 1'b0;
                        error_reg       <= 1'b0;
                        fail_code_reg   <= 2'd0;
                        write_count_reg <= '0;
                        retry_reg       <= '0;
                        rom_addr_reg    <= '0;
                        cnt_reg         <= '0;
                        state_reg       <= S_STARTUP;
                    end
                end
                S_STARTUP: begin
                    if (cnt_reg == 32'(STARTUP_CYCLES - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= S_FETCH;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                S_FETCH: state_reg <= S_DECODE;
                S_DECODE: begin
                    reg_addr_reg <= rom_ra;
                    wdata_reg    <= rom_v;
                    tick_reg     <= rom_v;
                    cnt_reg      <= '0;
                    is_write_reg <= 1'b0;
                    if (rom_ra == '1 && rom_v == '1) begin
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else if (rom_ra == '1) begin
                        state_reg <= S_DELAY;
                    end else begin
                        is_write_reg <= 1'b1;
                        state_reg    <= S_WR;
                    end
                end
                S_WR: begin
                    req_reg   <= 1'b1;
                    we_reg    <= 1'b1;
                    state_reg <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (xfer_err_i || xfer_done_i) begin
                        req_reg <= 1'b0;
                        if (!xfer_err_i) begin
                            state_reg <= (VERIFY != 0) ? S_RD : S_NEXT;
                        end
                    end
                end
                S_RD: begin
                    req_reg   <= 1'b1;
                    we_reg    <= 1'b0;
                    state_reg <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (xfer_err_i || xfer_done_i) begin
                        req_reg   <= 1'b0;
                        rdata_reg <= xfer_rdata_i;
                        if (!xfer_err_i) begin
                            state_reg <= S_CMP;
                        end
                    end
                end
                S_CMP: begin
                    if (rdata_reg == wdata_reg) begin
                        state_reg <= S_NEXT;
                    end
                end
                // (v+1) ticks of DELAY_UNIT cycles each; tick_reg counts v down to 0
                S_DELAY: begin
                    if (cnt_reg == 32'(DELAY_UNIT - 1)) begin
                        cnt_reg <= '0;
                        if (tick_reg == '0) begin
                            state_reg <= S_NEXT;
                        end else begin
                            tick_reg <= tick_reg - 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                S_NEXT: begin
                    if (is_write_reg) begin
                        write_count_reg <= write_count_reg + 1'b1;
                    end
                    retry_reg <= '0;
                    if (rom_addr_reg == '1) begin
                        error_reg      <= 1'b1;
                        fail_code_reg  <= 2'd3;
                        fail_index_reg <= rom_addr_reg;
                        state_reg      <= S_FAIL;
                    end else begin
                        rom_addr_reg <= rom_addr_reg + 1'b1;
                        state_reg    <= S_FETCH;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            if (fail_now) begin
                if (retry_reg < 4'(RETRIES)) begin
                    retry_reg <= retry_reg + 4'd1;
                    state_reg <= S_WR;
                end else begin
                    error_reg      <= 1'b1;
                    fail_code_reg  <= fail_kind;
                    fail_index_reg <= rom_addr_reg;
                    state_reg      <= S_FAIL;
                end
            end
        end
    end

    assign rom_addr_o    = rom_addr_reg;
    assign xfer_req_o    = req_reg;
    assign xfer_we_o     = we_reg;
    assign xfer_dev_o    = DEV_ADDR;
    assign xfer_reg_o    = reg_addr_reg;
    assign xfer_wdata_o  = wdata_reg;
    assign busy_o        = (state_reg != S_IDLE) && (state_reg != S_DONE) && (state_reg != S_FAIL);
    assign done_o        = done_reg;
    assign error_o       = error_reg;
    assign fail_code_o   = fail_code_reg;
    assign fail_index_o  = fail_index_reg;
    assign write_count_o = write_count_reg;

endmodule

// File: tb/tb_reg_init_sequencer.sv
// Directed bench: three sequencer instances (plain, verify, tiny table) share a clock and
// each gets a table model plus a bus responder that logs every completed transaction.
module tb_reg_init_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] start    = '0;
    logic [2:0] hold     = '0;
    logic [2:0] bus_req;
    logic [2:0] bus_we;
    logic [2:0] bus_done = '0;
    logic [2:0] bus_err  = '0;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] error;
    logic [7:0] bus_reg   [3];
    logic [7:0] bus_wdata [3];
    logic [6:0] dev       [3];
    logic [1:0] fcode     [3];
    logic [7:0] addr_a, addr_b, fidx_a, fidx_b;
    logic [8:0] wc_a, wc_b;
    logic [1:0] addr_c, fidx_c;
    logic [2:0] wc_c;
    logic [15:0] rom_a [256];
    logic [15:0] rom_b [256];
    logic [15:0] rom_c [4];

    logic       log_we  [3][32];
    logic       log_err [3][32];
    logic [7:0] log_reg [3][32];
    logic [7:0] log_wd  [3][32];
    int         log_n    [3];
    int         lat      [3];
    int         err_upto [3];
    int         checks   = 0;
    int         failures = 0;

    reg_init_sequencer #(
        .ROM_AW(8), .REG_AW(8), .DW(8), .DEV_ADDR(7'h21),
        .STARTUP_CYCLES(4), .DELAY_UNIT(10), .VERIFY(0), .RETRIES(1)
    ) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .start_i(start[0]),
        .rom_addr_o(addr_a), .rom_data_i(rom_a[addr_a]),
        .xfer_req_o(bus_req[0]), .xfer_we_o(bus_we[0]), .xfer_dev_o(dev[0]),
        .xfer_reg_o(bus_reg[0]), .xfer_wdata_o(bus_wdata[0]), .xfer_rdata_i(8'h00),
        .xfer_done_i(bus_done[0]), .xfer_err_i(bus_err[0]),
        .busy_o(busy[0]), .done_o(done[0]), .error_o(error[0]),
        .fail_code_o(fcode[0]), .fail_index_o(fidx_a), .write_count_o(wc_a)
    );

    reg_init_sequencer #(
        .ROM_AW(8), .REG_AW(8), .DW(8), .DEV_ADDR(7'h21),
        .STARTUP_CYCLES(4), .DELAY_UNIT(10), .VERIFY(1), .RETRIES(2)
    ) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .start_i(start[1]),
        .rom_addr_o(addr_b), .rom_data_i(rom_b[addr_b]),
        .xfer_req_o(bus_req[1]), .xfer_we_o(bus_we[1]), .xfer_dev_o(dev[1]),
        .xfer_reg_o(bus_reg[1]), .xfer_wdata_o(bus_wdata[1]), .xfer_rdata_i(8'h05),
        .xfer_done_i(bus_done[1]), .xfer_err_i(bus_err[1]),
        .busy_o(busy[1]), .done_o(done[1]), .error_o(error[1]),
        .fail_code_o(fcode[1]), .fail_index_o(fidx_b), .write_count_o(wc_b)
    );

    reg_init_sequencer #(
        .ROM_AW(2), .REG_AW(8), .DW(8), .DEV_ADDR(7'h21),
        .STARTUP_CYCLES(4), .DELAY_UNIT(10), .VERIFY(0), .RETRIES(0)
    ) dut_c (
        .sys_clk(clk), .sys_rst_n(rst_n), .start_i(start[2]),
        .rom_addr_o(addr_c), .rom_data_i(rom_c[addr_c]),
        .xfer_req_o(bus_req[2]), .xfer_we_o(bus_we[2]), .xfer_dev_o(dev[2]),
        .xfer_reg_o(bus_reg[2]), .xfer_wdata_o(bus_wdata[2]), .xfer_rdata_i(8'h00),
        .xfer_done_i(bus_done[2]), .xfer_err_i(bus_err[2]),
        .busy_o(busy[2]), .done_o(done[2]), .error_o(error[2]),
        .fail_code_o(fcode[2]), .fail_index_o(fidx_c), .write_count_o(wc_c)
    );

    // Responder: completes each request 3 cycles after it is seen; entries below err_upto get an error.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            bus_done[d] <= 1'b0;
            bus_err[d]  <= 1'b0;
            if (!bus_req[d]) begin
                lat[d] <= 0;
            end else if (!bus_done[d] && !bus_err[d] && !hold[d]) begin
                if (lat[d] == 2) begin
                    lat[d] <= 0;
                    if (log_n[d] < err_upto[d]) bus_err[d] <= 1'b1;
                    else bus_done[d] <= 1'b1;
                    if (log_n[d] < 32) begin
                        log_we[d][log_n[d]]  <= bus_we[d];
                        log_reg[d][log_n[d]] <= bus_reg[d];
                        log_wd[d][log_n[d]]  <= bus_wdata[d];
                        log_err[d][log_n[d]] <= (log_n[d] < err_upto[d]);
                    end
                    log_n[d] <= log_n[d] + 1;
                    $display("txn dut=%0d n=%0d we=%0b reg=%02h wdata=%02h resp=%s", d, log_n[d],
                             bus_we[d], bus_reg[d], bus_wdata[d], (log_n[d] < err_upto[d]) ? "err" : "ok");
                end else begin
                    lat[d] <= lat[d] + 1;
                end
            end
        end
    end

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
    endtask

    task automatic wait_end(input int d, output int n);
        n = 0;
        while (!(done[d] || error[d]) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_req !== 3'b000) begin failures++; $display("FAIL reset_req got=%b exp=000", bus_req); end
        checks++; if (busy !== 3'b000) begin failures++; $display("FAIL reset_busy got=%b exp=000", busy); end
        checks++; if (done !== 3'b000 || error !== 3'b000) begin failures++; $display("FAIL reset_flags done=%b error=%b exp=000/000", done, error); end
        checks++; if (addr_a !== 8'd0 || wc_a !== 9'd0 || fidx_a !== 8'd0 || fcode[0] !== 2'd0) begin
            failures++; $display("FAIL reset_regs addr=%0h wc=%0h fidx=%0h fcode=%0h exp=0", addr_a, wc_a, fidx_a, fcode[0]); end
        checks++; if (dev[0] !== 7'h21) begin failures++; $display("FAIL dev_addr got=%0h exp=21", dev[0]); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;
        rom_a[0] = 16'h1280;
        rom_a[1] = 16'h1101;
    endtask

    task automatic test_basic_writes();
        int n;
        int base;
        load_basic();
        base = log_n[0];
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", busy[0]); end
        pulse_start(0);
        checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy[0]); end
        wait_end(0, n);
        checks++; if (n >= 3000) begin failures++; $display("FAIL basic_timeout got=%0d cycles exp<3000", n); end
        checks++; if (log_n[0] - base !== 2) begin failures++; $display("FAIL basic_txn_count got=%0d exp=2", log_n[0] - base); end
        checks++; if (log_reg[0][base] !== 8'h12 || log_wd[0][base] !== 8'h80 || log_we[0][base] !== 1'b1) begin
            failures++; $display("FAIL basic_txn0 got=%02h/%02h we=%b exp=12/80 we=1", log_reg[0][base], log_wd[0][base], log_we[0][base]); end
        checks++; if (log_reg[0][base+1] !== 8'h11 || log_wd[0][base+1] !== 8'h01 || log_we[0][base+1] !== 1'b1) begin
            failures++; $display("FAIL basic_txn1 got=%02h/%02h we=%b exp=11/01 we=1", log_reg[0][base+1], log_wd[0][base+1], log_we[0][base+1]); end
        checks++; if (done[0] !== 1'b1 || error[0] !== 1'b0 || busy[0] !== 1'b0) begin
            failures++; $display("FAIL basic_end done=%b error=%b busy=%b exp=1/0/0", done[0], error[0], busy[0]); end
        checks++; if (wc_a !== 9'd2) begin failures++; $display("FAIL basic_wcount got=%0d exp=2", wc_a); end
    endtask

    task automatic test_delay();
        int n;
        int base;
        for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;
        rom_a[0] = 16'hFF04;
        base = log_n[0];
        pulse_start(0);
        wait_end(0, n);
        // start edge -> 4 STARTUP, FETCH, DECODE, 5*10 DELAY, NEXT, FETCH, DECODE(END) = 59 edges
        checks++; if (n !== 59) begin failures++; $display("FAIL delay_cycles got=%0d exp=59", n); end
        checks++; if (log_n[0] !== base) begin failures++; $display("FAIL delay_no_bus got=%0d txns exp=0", log_n[0] - base); end
        checks++; if (done[0] !== 1'b1 || wc_a !== 9'd0) begin failures++; $display("FAIL delay_end done=%b wc=%0d exp=1/0", done[0], wc_a); end
    endtask

    task automatic test_retry();
        int n;
        int base;
        for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;
        rom_a[0] = 16'h1234;
        base = log_n[0];
        err_upto[0] = base + 1;
        pulse_start(0);
        wait_end(0, n);
        checks++; if (log_n[0] - base !== 2) begin failures++; $display("FAIL retry_txn_count got=%0d exp=2", log_n[0] - base); end
        checks++; if (log_err[0][base] !== 1'b1 || log_err[0][base+1] !== 1'b0) begin
            failures++; $display("FAIL retry_resp got=%b,%b exp=1,0", log_err[0][base], log_err[0][base+1]); end
        checks++; if (log_reg[0][base+1] !== 8'h12 || log_wd[0][base+1] !== 8'h34) begin
            failures++; $display("FAIL retry_same_entry got=%02h/%02h exp=12/34", log_reg[0][base+1], log_wd[0][base+1]); end
        checks++; if (done[0] !== 1'b1 || error[0] !== 1'b0 || wc_a !== 9'd1 || fcode[0] !== 2'd0) begin
            failures++; $display("FAIL retry_end done=%b error=%b wc=%0d code=%0d exp=1/0/1/0", done[0], error[0], wc_a, fcode[0]); end
    endtask

    task automatic test_verify_fail();
        int n;
        for (int i = 0; i < 256; i++) rom_b[i] = 16'hFFFF;
        rom_b[0] = 16'h3A04;
        pulse_start(1);
        wait_end(1, n);
        checks++; if (log_n[1] !== 6) begin failures++; $display("FAIL verify_txn_count got=%0d exp=6", log_n[1]); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (log_we[1][i] !== ((i % 2) == 0) || log_reg[1][i] !== 8'h3A) begin
                failures++; $display("FAIL verify_txn%0d got we=%b reg=%02h exp we=%0d reg=3a", i, log_we[1][i], log_reg[1][i], ((i % 2) == 0));
            end
        end
        checks++; if (log_wd[1][0] !== 8'h04) begin failures++; $display("FAIL verify_wdata got=%02h exp=04", log_wd[1][0]); end
        checks++; if (error[1] !== 1'b1 || done[1] !== 1'b0 || fcode[1] !== 2'd2 || fidx_b !== 8'd0) begin
            failures++; $display("FAIL verify_end error=%b done=%b code=%0d idx=%0d exp=1/0/2/0", error[1], done[1], fcode[1], fidx_b); end
    endtask

    task automatic test_no_terminator();
        int n;
        rom_c[0] = 16'h0111;
        rom_c[1] = 16'h0222;
        rom_c[2] = 16'h0333;
        rom_c[3] = 16'h0444;
        pulse_start(2);
        wait_end(2, n);
        checks++; if (log_n[2] !== 4) begin failures++; $display("FAIL noterm_txn_count got=%0d exp=4", log_n[2]); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_reg[2][i] !== 8'(i + 1)) begin
                failures++; $display("FAIL noterm_txn%0d got reg=%02h exp=%02h", i, log_reg[2][i], i + 1);
            end
        end
        checks++; if (error[2] !== 1'b1 || fcode[2] !== 2'd3 || fidx_c !== 2'd3 || addr_c !== 2'd3) begin
            failures++; $display("FAIL noterm_end error=%b code=%0d idx=%0d addr=%0d exp=1/3/3/3", error[2], fcode[2], fidx_c, addr_c); end
        checks++; if (wc_c !== 3'd4 || done[2] !== 1'b0) begin failures++; $display("FAIL noterm_wc got=%0d done=%b exp=4/0", wc_c, done[2]); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int base;
        load_basic();
        hold[0] = 1'b1;
        pulse_start(0);
        n = 0;
        while (!bus_req[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (bus_req[0] !== 1'b1) begin failures++; $display("FAIL midrst_req_rise got=%b exp=1", bus_req[0]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus_req[0] !== 1'b0 || busy[0] !== 1'b0) begin failures++; $display("FAIL midrst_req_drop req=%b busy=%b exp=0/0", bus_req[0], busy[0]); end
        checks++; if (addr_a !== 8'd0 || wc_a !== 9'd0 || done[0] !== 1'b0 || error[0] !== 1'b0) begin
            failures++; $display("FAIL midrst_outputs addr=%0h wc=%0h done=%b error=%b exp=0", addr_a, wc_a, done[0], error[0]); end
        @(posedge clk); #1;
        rst_n   = 1'b1;
        hold[0] = 1'b0;
        @(posedge clk); #1;
        base = log_n[0];
        pulse_start(0);
        n = 0;
        while (log_n[0] == base && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        pulse_start(0);
        wait_end(0, n);
        checks++; if (log_n[0] - base !== 2) begin failures++; $display("FAIL rerun_txn_count got=%0d exp=2", log_n[0] - base); end
        checks++; if (log_reg[0][base] !== 8'h12 || log_reg[0][base+1] !== 8'h11) begin
            failures++; $display("FAIL rerun_order got=%02h,%02h exp=12,11", log_reg[0][base], log_reg[0][base+1]); end
        checks++; if (done[0] !== 1'b1 || wc_a !== 9'd2) begin failures++; $display("FAIL rerun_end done=%b wc=%0d exp=1/2", done[0], wc_a); end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom_a[i] = 16'hFFFF;
            rom_b[i] = 16'hFFFF;
        end
        for (int i = 0; i < 4; i++) rom_c[i] = 16'hFFFF;
        test_reset();
        test_basic_writes();
        test_delay();
        test_retry();
        test_verify_fail();
        test_no_terminator();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_init_sequencer.md
Name: reg_init_sequencer

Overview:
- Generalised sensor register-init engine: walks a register/value table, issues one bus write per entry through an abstract transaction port, honours in-table delay and end markers, optionally reads back and verifies, and retries failures.
- Sits between a combinational settings ROM and the I2C/SCCB transaction controller. Replaces hard-coded, single-width init sequencing for OV7670 and 16-bit-register sensors.

Parameters:
- ROM_AW, 8, table address width; table depth 2^ROM_AW.
- REG_AW, 8, register address width (8 or 16).
- DW, 8, register data width.
- DEV_ADDR, 7'h21, 7-bit bus device address driven on xfer_dev_o.
- STARTUP_CYCLES, 1000, idle cycles after start before the first fetch (min 1).
- DELAY_UNIT, 1000, sys_clk cycles per delay-marker tick.
- VERIFY, 0, 1 = read back each write and compare.
- RETRIES, 2, extra attempts per entry after a failure (0..15).

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; starts the sequence.
- rom_addr_o  out  ROM_AW  table index.
- rom_data_i  in  REG_AW+DW  {reg_addr, value}; combinational, valid 1 cycle after rom_addr_o changes.
- xfer_req_o  out  1  transaction request, held until completion.
- xfer_we_o  out  1  1 = write, 0 = read.
- xfer_dev_o  out  7  equals DEV_ADDR.
- xfer_reg_o  out  REG_AW  register address.
- xfer_wdata_o  out  DW  write data.
- xfer_rdata_i  in  DW  read data, valid with xfer_done_i.
- xfer_done_i  in  1  completion pulse.
- xfer_err_i  in  1  NACK or bus error pulse.
- busy_o  out  1  sequence running.
- done_o  out  1  sticky; sequence ended successfully.
- error_o  out  1  sticky; sequence aborted.
- fail_code_o  out  2  0 = none, 1 = bus error, 2 = verify mismatch, 3 = missing terminator.
- fail_index_o  out  ROM_AW  entry index at abort.
- write_count_o  out  ROM_AW+1  writes committed (count includes retried entries once).

Behaviour:
- Reset, asynchronous: state IDLE.
  - All outputs 0.
  - rom_addr_o = 0, counters cleared.
  - xfer_req_o drops immediately, including mid-transaction.
- States: IDLE, STARTUP, FETCH, DECODE, WR, WR_WAIT, RD, RD_WAIT, CMP, DELAY, NEXT, DONE, FAIL.
- IDLE:
  - start_i clears done_o, error_o, fail_code_o, write_count_o and the retry counter, and sets rom_addr_o = 0.
  - Next state STARTUP; busy_o = 1 from the next cycle.
  - start_i is ignored in every state except IDLE, DONE and FAIL.
- STARTUP: counts STARTUP_CYCLES, then FETCH.
- FETCH: one-cycle ROM settle, then DECODE.
- DECODE, where ra = upper REG_AW bits and v = lower DW bits of rom_data_i:
  - ra all-ones and v all-ones: END, go to DONE.
  - ra all-ones, any other v: DELAY for (v+1)*DELAY_UNIT cycles, no bus traffic, then NEXT.
  - Otherwise: WR. Register address all-ones is therefore not writable.
- WR / WR_WAIT:
  - xfer_req_o = 1, xfer_we_o = 1, xfer_reg_o = ra, xfer_wdata_o = v.
  - Request is held stable until xfer_done_i or xfer_err_i, then dropped the next cycle.
  - If xfer_done_i and xfer_err_i arrive in the same cycle, error wins.
  - On done: go to RD if VERIFY = 1, else NEXT.
- RD / RD_WAIT: same handshake with xfer_we_o = 0. On done, capture xfer_rdata_i and go to CMP.
- CMP: equal goes to NEXT; unequal is a failure with code 2.
- Failure, code 1 or 2:
  - If retries used < RETRIES: increment retries and go back to WR with the same entry.
  - Otherwise: FAIL with fail_code_o set and fail_index_o = rom_addr_o.
- NEXT:
  - Increments write_count_o if the entry was a write.
  - Resets the retry counter.
  - If rom_addr_o = 2^ROM_AW-1, go to FAIL with code 3 and no wrap. Otherwise increment rom_addr_o and go to FETCH.
- DONE: done_o = 1, busy_o = 0.
- FAIL: error_o = 1, busy_o = 0.
- DONE and FAIL hold until start_i or reset.
- Spurious xfer_done_i or xfer_err_i outside WR_WAIT/RD_WAIT is ignored.

Test Plan:
- Table {12,80},{11,01},{FF,FF}, VERIFY=0, start_i: two writes, reg 12h data 80h then reg 11h data 01h. Then done_o=1, write_count_o=2, error_o=0.
- Table {FF,04},{FF,FF}, DELAY_UNIT=10: no xfer_req_o. Exactly 50 cycles are spent in DELAY, then done_o=1.
- VERIFY=1, RETRIES=2, write 3Ah=04h with rdata always 05h: three write+read pairs, then error_o=1, fail_code_o=2, fail_index_o=0.
- Return xfer_err_i on the first attempt, success on the second (RETRIES=1): done_o=1, write_count_o=1, error_o=0.
- ROM_AW=2 with no terminator (four normal entries): four writes, then fail_code_o=3, fail_index_o=3.
- Assert sys_rst_n=0 during WR_WAIT: xfer_req_o=0 in the same cycle, all outputs 0. Then start_i gives a clean rerun from entry 0. A mid-run start_i is ignored.
